dm_responder: RTL and testbench

- Memory-side responder for the pipelined CPU's data port. It accepts one load or store request at a time over a valid/ready handshake.
- It waits a programmable number of cycles to model memory latency, then performs the access on an internal word array.
- It returns the read data or a write acknowledgement over a second valid/ready handshake.
- It replaces the zero-latency data memory when stall-capable pipeline control is exercised.

---
 rtl/dm_responder_pkg.sv | 26 ++
 rtl/dm_responder_array.sv | 27 ++
 rtl/dm_responder.sv | 149 ++++++++++++++
 tb/tb_dm_responder.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_responder_pkg.sv
// Shared types and helpers for the data-memory responder.
package dm_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int CNT_W = 4;

    // Replace the bytes of old_word selected by be with the matching bytes of new_word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/dm_responder_array.sv
// Single-port word array: combinational read, byte-masked synchronous write, no reset.
module dm_responder_array
    import dm_responder_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic          wen,
    input  logic [3:0]    be,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // Byte-merged write; unselected bytes keep their old contents.
    always_ff @(posedge clk) begin
        if (wen) begin
            mem[addr] <= merge_bytes(mem[addr], wdata, be);
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dm_responder.sv
// Memory-side responder with programmable latency for the CPU data port.
// Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
// the requester holds req_* stable until accepted, and the responder holds
// rsp_* stable while rsp_valid is high until rsp_ready is seen.
module dm_responder
    import dm_responder_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int IDX_W = ADDR_W - 2;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W:0]   DEPTH_L  = (IDX_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY == 0) ? 0 : LATENCY - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;

    logic             cap_we;
    logic [IDX_W-1:0] cap_idx;
    logic [31:0]      cap_wdata;
    logic [3:0]       cap_be;

    logic [31:0]      rdata_q;
    logic             err_q;

    logic             accept, commit, in_range, arr_wen;
    logic             acc_we;
    logic [IDX_W-1:0] acc_idx;
    logic [31:0]      acc_wdata, arr_rdata;
    logic [3:0]       acc_be;
    logic [1:0]       unused_addr_bits;

    assign unused_addr_bits = req_addr[1:0];

    assign accept = req_valid && (state == IDLE);

    // With zero latency the access happens on the acceptance edge using the live
    // request; otherwise it happens from the captured request when WAIT expires.
    assign commit    = (LATENCY == 0) ? accept : ((state == WAIT) && (cnt == '0));
    assign acc_we    = (state == IDLE) ? req_we            : cap_we;
    assign acc_idx   = (state == IDLE) ? req_addr[ADDR_W-1:2] : cap_idx;
    assign acc_wdata = (state == IDLE) ? req_wdata         : cap_wdata;
    assign acc_be    = (state == IDLE) ? req_be            : cap_be;

    assign in_range = {1'b0, acc_idx} < DEPTH_L;
    // Reset wins over a commit landing on the same edge.
    assign arr_wen  = commit && acc_we && in_range && !rst;

    dm_responder_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .addr  (acc_idx[AW-1:0]),
        .wen   (arr_wen),
        .be    (acc_be),
        .wdata (acc_wdata),
        .rdata (arr_rdata)
    );

    // State and latency counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 0) begin
                        state_n = RESP;
                    end else begin
                        state_n = WAIT;
                        cnt_n   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_n = RESP;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Capture the request on acceptance; contents only matter once accepted.
    always_ff @(posedge clk) begin
        if (accept) begin
            cap_we    <= req_we;
            cap_idx   <= req_addr[ADDR_W-1:2];
            cap_wdata <= req_wdata;
            cap_be    <= req_be;
        end
    end

    // Response registers: loaded at commit, error cleared on the response handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (commit) begin
            rdata_q <= (!acc_we && in_range) ? arr_rdata : '0;
            err_q   <= !in_range;
        end else if ((state == RESP) && rsp_ready) begin
            err_q   <= 1'b0;
        end
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: three instances (LATENCY 2, 0, 3; DEPTH 512).
module tb_dm_responder;

    localparam int NI    = 3;
    localparam int DEPTH = 512;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid [NI];
    logic        req_ready [NI];
    logic        req_we    [NI];
    logic [11:0] req_addr  [NI];
    logic [31:0] req_wdata [NI];
    logic [3:0]  req_be    [NI];
    logic        rsp_valid [NI];
    logic        rsp_ready [NI];
    logic [31:0] rsp_rdata [NI];
    logic        rsp_err   [NI];
    logic        busy      [NI];

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] exp_q [$];
    logic [31:0] model_mem   [NI][1024];
    logic [3:0]  model_known [NI][1024];

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [10];

    dm_responder #(.ADDR_W(12), .DEPTH(DEPTH), .LATENCY(2)) u_lat2 (
        .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .req_be(req_be[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]), .busy(busy[0])
    );

    dm_responder #(.ADDR_W(12), .DEPTH(DEPTH), .LATENCY(0)) u_lat0 (
        .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .req_be(req_be[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]), .busy(busy[1])
    );

    dm_responder #(.ADDR_W(12), .DEPTH(DEPTH), .LATENCY(3)) u_lat3 (
        .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_we(req_we[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
        .req_be(req_be[2]), .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
        .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]), .busy(busy[2])
    );

    // Clock.
    always #5 clk = ~clk;

    // Time limit.
    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, %0d tests run", tests_run);
        $fatal(1, "time limit");
    end

    function automatic int lat_of(input int k);
        case (k)
            0:       return 2;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_idle(input int k, input string name);
        check({name, "_req_ready"}, req_ready[k], 1);
        check({name, "_rsp_valid"}, rsp_valid[k], 0);
        check({name, "_rsp_rdata"}, rsp_rdata[k], 0);
        check({name, "_rsp_err"},   rsp_err[k],   0);
        check({name, "_busy"},      busy[k],      0);
    endtask

    // Reference model: expected response for a request, then apply any store.
    task automatic model_apply(input int k, input logic we, input logic [11:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be,
                               output logic [31:0] exp, output logic [31:0] mask,
                               output logic exp_err);
        int idx;
        idx  = int'(addr[11:2]);
        exp  = 32'h0;
        mask = 32'hFFFF_FFFF;
        exp_err = 1'b0;
        if (idx >= DEPTH) begin
            exp_err = 1'b1;
        end else if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    model_mem[k][idx][8*i +: 8] = wdata[8*i +: 8];
                    model_known[k][idx][i] = 1'b1;
                end
            end
        end else begin
            exp = model_mem[k][idx];
            for (int i = 0; i < 4; i++) begin
                if (!model_known[k][idx][i]) mask[8*i +: 8] = 8'h00;
            end
        end
    endtask

    // One request/response; checks latency, response stability while stalled
    // (with a competing request offered), and the return to idle.
    task automatic txn(input int k, input logic we, input logic [11:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be, input int hold,
                       output logic [31:0] rdata, output logic err);
        int guard;
        logic [31:0] held;
        rdata = 32'h0;
        err   = 1'b0;
        @(negedge clk);
        req_valid[k] = 1'b1; req_we[k] = we; req_addr[k] = addr;
        req_wdata[k] = wdata; req_be[k] = be; rsp_ready[k] = 1'b0;
        guard = 0;
        while (!req_ready[k] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready[k]) begin
            check("accept_timeout", 0, 1);
            req_valid[k] = 1'b0;
            return;
        end
        @(negedge clk);
        req_valid[k] = 1'b0;
        guard = 0;
        while (!rsp_valid[k] && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (!rsp_valid[k]) begin
            check("rsp_timeout", 0, 1);
            return;
        end
        // guard+1 = edges from acceptance to the first edge that samples rsp_valid high
        check("latency", guard + 1, lat_of(k) + 1);
        rdata = rsp_rdata[k];
        err   = rsp_err[k];
        held  = rdata;
        for (int i = 0; i < hold; i++) begin
            req_valid[k] = 1'b1; req_we[k] = 1'b1; req_wdata[k] = 32'h0; req_be[k] = 4'hF;
            @(negedge clk);
            check("hold_rsp_valid", rsp_valid[k], 1);
            check("hold_rsp_rdata", rsp_rdata[k], held);
            check("hold_rsp_err",   rsp_err[k],   err);
            check("hold_req_ready", req_ready[k], 0);
        end
        req_valid[k] = 1'b0;
        rsp_ready[k] = 1'b1;
        @(negedge clk);
        rsp_ready[k] = 1'b0;
        check("post_rsp_valid", rsp_valid[k], 0);
        check("post_req_ready", req_ready[k], 1);
        check("post_rsp_err",   rsp_err[k],   0);
        check("post_rdata_held", rsp_rdata[k], held);
    endtask

    task automatic run_check(input int k, input logic we, input logic [11:0] addr,
                             input logic [31:0] wdata, input logic [3:0] be,
                             input int hold, input string name);
        logic [31:0] exp, mask, act;
        logic        exp_err, act_err;
        model_apply(k, we, addr, wdata, be, exp, mask, exp_err);
        exp_q.push_back(exp & mask);
        txn(k, we, addr, wdata, be, hold, act, act_err);
        check({name, "_rdata"}, act & mask, exp_q.pop_front());
        check({name, "_err"},   act_err,    exp_err);
    endtask

    initial begin
        logic [31:0] act, exp, mask;
        logic        act_err, exp_err;
        logic        acc [12];
        int          n_acc, guard;
        logic [9:0]  idx;

        vecs[0] = '{1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        vecs[1] = '{1'b0, 12'h010, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        vecs[2] = '{1'b1, 12'h010, 32'h11223344, 4'h5, 32'h0,        1'b0};
        vecs[3] = '{1'b0, 12'h010, 32'h0,        4'h0, 32'hDE22BE44, 1'b0};
        vecs[4] = '{1'b1, 12'h010, 32'hFFFFFFFF, 4'h0, 32'h0,        1'b0};
        vecs[5] = '{1'b0, 12'h010, 32'h0,        4'h0, 32'hDE22BE44, 1'b0};
        vecs[6] = '{1'b1, 12'h100, 32'hA5A5A5A5, 4'hF, 32'h0,        1'b0};
        vecs[7] = '{1'b0, 12'h900, 32'h0,        4'h0, 32'h0,        1'b1};
        vecs[8] = '{1'b1, 12'h900, 32'h55555555, 4'hF, 32'h0,        1'b1};
        vecs[9] = '{1'b0, 12'h100, 32'h0,        4'h0, 32'hA5A5A5A5, 1'b0};

        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < 1024; i++) begin
                model_mem[k][i]   = 32'h0;
                model_known[k][i] = 4'h0;
            end
            req_valid[k] = 1'b0; req_we[k] = 1'b0; req_addr[k] = 12'h0;
            req_wdata[k] = 32'h0; req_be[k] = 4'h0; rsp_ready[k] = 1'b0;
        end

        // Reset.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < NI; k++) check_idle(k, "reset");

        // Directed vectors on the LATENCY=2 instance.
        for (int i = 0; i < 10; i++) begin
            model_apply(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, exp, mask, exp_err);
            txn(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, 0, act, act_err);
            check($sformatf("vec%0d_rdata", i), act, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i),   act_err, vecs[i].exp_err);
        end

        // Stalled response for 5 cycles with a competing store offered; it must not land.
        txn(0, 1'b0, 12'h010, 32'h0, 4'h0, 5, act, act_err);
        check("stall_rdata", act, 32'hDE22BE44);
        txn(0, 1'b0, 12'h010, 32'h0, 4'h0, 0, act, act_err);
        check("after_stall_rdata", act, 32'hDE22BE44);

        // Back-to-back loads on LATENCY=0 with req_valid and rsp_ready held high.
        run_check(1, 1'b1, 12'h040, 32'h0BADF00D, 4'hF, 0, "b2b_store");
        @(negedge clk);
        req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 12'h040; req_be[1] = 4'h0;
        rsp_ready[1] = 1'b1;
        n_acc = 0;
        for (int c = 0; c < 12; c++) begin
            acc[c] = req_ready[1];
            if (acc[c]) n_acc++;
            if (c > 0) check("b2b_rsp_valid", rsp_valid[1], acc[c-1]);
            if (rsp_valid[1]) check("b2b_rdata", rsp_rdata[1], 32'h0BADF00D);
            @(negedge clk);
        end
        req_valid[1] = 1'b0;
        repeat (3) @(negedge clk);
        rsp_ready[1] = 1'b0;
        check("b2b_first_accept", acc[0], 1);
        check("b2b_accept_count", n_acc, 6);

        // Reset one cycle into WAIT during a store (LATENCY=3): aborted, no write.
        run_check(2, 1'b1, 12'h020, 32'h12345678, 4'hF, 0, "pre_store");
        @(negedge clk);
        req_valid[2] = 1'b1; req_we[2] = 1'b1; req_addr[2] = 12'h020;
        req_wdata[2] = 32'hCAFEF00D; req_be[2] = 4'hF;
        @(negedge clk);
        req_valid[2] = 1'b0;
        check("wait_busy", busy[2], 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle(2, "rst_wait");
        repeat (5) @(negedge clk);
        run_check(2, 1'b0, 12'h020, 32'h0, 4'h0, 0, "after_rst_wait");

        // Reset while in RESP: the committed store persists, response dropped.
        @(negedge clk);
        req_valid[2] = 1'b1; req_we[2] = 1'b1; req_addr[2] = 12'h030;
        req_wdata[2] = 32'hABCD1234; req_be[2] = 4'hF;
        @(negedge clk);
        req_valid[2] = 1'b0;
        guard = 0;
        while (!rsp_valid[2] && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("resp_reached", rsp_valid[2], 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle(2, "rst_resp");
        model_apply(2, 1'b1, 12'h030, 32'hABCD1234, 4'hF, exp, mask, exp_err);
        run_check(2, 1'b0, 12'h030, 32'h0, 4'h0, 0, "after_rst_resp");

        // Randomized traffic against the reference model.
        for (int k = 0; k < NI; k++) begin
            for (int n = 0; n < 30; n++) begin
                if ($urandom_range(0, 7) == 0) idx = 10'($urandom_range(512, 1023));
                else                           idx = 10'($urandom_range(0, 15));
                run_check(k, 1'($urandom_range(0, 1)),
                          {idx, 2'($urandom_range(0, 3))},
                          $urandom, 4'($urandom_range(0, 15)),
                          $urandom_range(0, 2), $sformatf("rand_k%0d_n%0d", k, n));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
